// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the DataPath.
// Sequences T0-T6 and drives every bus-drive, load, memory and ALU-select line.
module control_sequencer #(
  parameter int OP_W = 5,
  parameter int IR_W = 32
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [IR_W-1:0] IR,
  input  logic            MemReady,
  input  logic            Stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic            Rout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            HIin,
  output logic            LOin,
  output logic            Rin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic [OP_W-1:0] ALU_op,
  output logic            Run,
  output logic            IllegalOp
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

  state_t          state, next_state;
  logic            stop_flag;
  logic            t1_repeat;
  logic [OP_W-1:0] opcode;
  logic            is_alu, is_muldiv;
  state_t          end_state;
  logic            unused_ir;

  assign opcode    = IR[IR_W-1 -: OP_W];
  assign unused_ir = ^IR[IR_W-OP_W-1:0];
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  // A Stop seen up to and including the final edge diverts the return to T0 into HALT.
  assign end_state = (stop_flag || Stop) ? HALT : T0;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= T0;
      stop_flag <= 1'b0;
      t1_repeat <= 1'b0;
    end else begin
      state     <= next_state;
      stop_flag <= stop_flag | Stop;
      t1_repeat <= (state == T1) && !MemReady;
    end
  end

  // Outputs are forced quiet (Run excepted) for as long as Clear is held low.
  always_comb begin
    next_state = state;
    PCout = 1'b0;  Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; Rout = 1'b0;
    PCin  = 1'b0;  MARin   = 1'b0; MDRin    = 1'b0; IRin   = 1'b0; Yin  = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin     = 1'b0; LOin   = 1'b0; Rin  = 1'b0;
    IncPC = 1'b0;  Read    = 1'b0; Gra      = 1'b0; Grb    = 1'b0; Grc  = 1'b0;
    ALU_op    = '0;
    IllegalOp = 1'b0;
    Run       = (state != HALT);
    if (Clear) begin
      case (state)
        T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
          ALU_op = OP_ADD;
          next_state = T1;
        end
        T1: begin
          Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
          PCin = !t1_repeat;
          if (MemReady) next_state = T2;
        end
        T2: begin
          MDRout = 1'b1; IRin = 1'b1;
          next_state = T3;
        end
        T3: begin
          if (is_alu || is_muldiv) begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = T4;
          end else if (opcode == OP_NOP) begin
            next_state = end_state;
          end else if (opcode == OP_HALT) begin
            next_state = HALT;
          end else begin
            IllegalOp  = 1'b1;
            next_state = end_state;
          end
        end
        T4: begin
          Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1;
          ZHighIn = is_muldiv;
          ALU_op = opcode;
          next_state = T5;
        end
        T5: begin
          Zlowout = 1'b1;
          if (is_muldiv) begin
            LOin = 1'b1;
            next_state = T6;
          end else begin
            Gra = 1'b1; Rin = 1'b1;
            next_state = end_state;
          end
        end
        T6: begin
          ZHighout = 1'b1; HIin = 1'b1;
          next_state = end_state;
        end
        HALT: next_state = HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control words are queued
// with their MemReady/Stop stimulus and compared one per clock.
module tb_control_sequencer;

  logic        Clock, Clear, MemReady, Stop;
  logic [31:0] IR;
  logic        PCout, Zlowout, ZHighout, MDRout, Rout, PCin, MARin, MDRin, IRin, Yin;
  logic        ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read, Gra, Grb, Grc, Run, IllegalOp;
  logic [4:0]  ALU_op;
  logic [26:0] ctl, exp_w;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [26:0] exp_q[$];
  logic        mem_q[$];
  logic        stop_q[$];

  localparam logic [26:0] B_PCOUT = 27'h1 << 26, B_ZLOWOUT = 27'h1 << 25, B_ZHIGHOUT = 27'h1 << 24;
  localparam logic [26:0] B_MDROUT = 27'h1 << 23, B_ROUT = 27'h1 << 22, B_PCIN = 27'h1 << 21;
  localparam logic [26:0] B_MARIN = 27'h1 << 20, B_MDRIN = 27'h1 << 19, B_IRIN = 27'h1 << 18;
  localparam logic [26:0] B_YIN = 27'h1 << 17, B_ZLOWIN = 27'h1 << 16, B_ZHIGHIN = 27'h1 << 15;
  localparam logic [26:0] B_HIIN = 27'h1 << 14, B_LOIN = 27'h1 << 13, B_RIN = 27'h1 << 12;
  localparam logic [26:0] B_INCPC = 27'h1 << 11, B_READ = 27'h1 << 10, B_GRA = 27'h1 << 9;
  localparam logic [26:0] B_GRB = 27'h1 << 8, B_GRC = 27'h1 << 7, B_RUN = 27'h1 << 6;
  localparam logic [26:0] B_ILL = 27'h1 << 5;

  localparam logic [26:0] W_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_RUN | 27'd3;
  localparam logic [26:0] W_T1F = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [26:0] W_T1S = B_ZLOWOUT | B_READ | B_MDRIN | B_RUN;
  localparam logic [26:0] W_T2  = B_MDROUT | B_IRIN | B_RUN;

  assign ctl = {PCout, Zlowout, ZHighout, MDRout, Rout, PCin, MARin, MDRin, IRin, Yin,
                ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read, Gra, Grb, Grc, Run, IllegalOp,
                ALU_op};

  control_sequencer #(.OP_W(5), .IR_W(32)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .ALU_op(ALU_op), .Run(Run), .IllegalOp(IllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_cycle(input logic [26:0] w, input logic mem, input logic stp);
    exp_q.push_back(w);
    mem_q.push_back(mem);
    stop_q.push_back(stp);
  endtask

  // Reference model: expected control word for every cycle of one instruction.
  task automatic push_instr(input logic [31:0] ir, input int stalls, input int stop_idx,
                            input int halt_words);
    logic [4:0] op;
    logic alu, md;
    int idx;
    op  = ir[31:27];
    alu = (op == 5'b00011) || (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
    md  = (op == 5'b01111) || (op == 5'b10000);
    idx = 0;
    push_cycle(W_T0, 1'b1, idx == stop_idx); idx++;
    push_cycle(W_T1F, stalls == 0, idx == stop_idx); idx++;
    for (int k = 1; k <= stalls; k++) begin
      push_cycle(W_T1S, k == stalls, idx == stop_idx); idx++;
    end
    push_cycle(W_T2, 1'b1, idx == stop_idx); idx++;
    if (alu || md) begin
      push_cycle(B_GRB | B_ROUT | B_YIN | B_RUN, 1'b1, idx == stop_idx); idx++;
      push_cycle(B_GRC | B_ROUT | B_ZLOWIN | B_RUN | (md ? B_ZHIGHIN : 27'h0) | {22'h0, op},
                 1'b1, idx == stop_idx); idx++;
      if (md) begin
        push_cycle(B_ZLOWOUT | B_LOIN | B_RUN, 1'b1, idx == stop_idx); idx++;
        push_cycle(B_ZHIGHOUT | B_HIIN | B_RUN, 1'b1, idx == stop_idx); idx++;
      end else begin
        push_cycle(B_ZLOWOUT | B_GRA | B_RIN | B_RUN, 1'b1, idx == stop_idx); idx++;
      end
    end else if (op == 5'b11010 || op == 5'b11011) begin
      push_cycle(B_RUN, 1'b1, idx == stop_idx); idx++;
    end else begin
      push_cycle(B_RUN | B_ILL, 1'b1, idx == stop_idx); idx++;
    end
    for (int h = 0; h < halt_words; h++) push_cycle(27'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    Clear = 1'b0; MemReady = 1'b0; Stop = 1'b0; IR = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clock); #1;
      n_compared++;
      if (ctl !== B_RUN) begin
        n_mismatched++;
        $display("[TB] FAIL reset_hold cyc %0d: got %h, expected %h", c, ctl, B_RUN);
      end
    end
    Clear = 1'b1; #1;
    n_compared++;
    if (ctl !== W_T0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release_t0: got %h, expected %h", ctl, W_T0);
    end
  endtask

  task automatic test_and();
    int cyc = 0;
    IR = 32'h28918000;
    push_instr(IR, 0, -1, 0);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL and_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    #1;
    n_compared++;
    if (ctl !== W_T0) begin
      n_mismatched++;
      $display("[TB] FAIL and_back_in_t0 after %0d cycles: got %h, expected %h", cyc, ctl, W_T0);
    end
  endtask

  task automatic test_mul();
    int cyc = 0;
    int zh  = 0;
    IR = 32'h78A00000;
    push_instr(IR, 0, -1, 0);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      if (ZHighIn) zh++;
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL mul_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    #1;
    n_compared++;
    if (ctl !== W_T0 || zh != 1) begin
      n_mismatched++;
      $display("[TB] FAIL mul_latency: got ctl %h zhighin_cycles %0d, expected %h and 1", ctl, zh, W_T0);
    end
  endtask

  task automatic test_mem_stall();
    int cyc = 0;
    int rd = 0, pc = 0, irn = 0;
    IR = 32'h18000000;
    push_instr(IR, 3, -1, 0);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      rd += int'(Read); pc += int'(PCin); irn += int'(IRin);
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL stall_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    n_compared++;
    if (rd != 4 || pc != 1 || irn != 1) begin
      n_mismatched++;
      $display("[TB] FAIL stall_counts: got read=%0d pcin=%0d irin=%0d, expected 4 1 1", rd, pc, irn);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    logic [31:0] prog[3] = '{32'hD0000000, 32'h80000000, 32'h20000000};
    for (int i = 0; i < 3; i++) begin
      IR = prog[i];
      push_instr(IR, 0, -1, 0);
      while (exp_q.size() != 0) begin
        MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
        exp_w = exp_q.pop_front();
        n_compared++;
        if (ctl !== exp_w) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_seq instr %0d cyc %0d: got %h, expected %h", i, cyc, ctl, exp_w);
        end
        cyc++;
        @(negedge Clock);
      end
    end
  endtask

  task automatic test_illegal_and_clear();
    int cyc = 0;
    IR = 32'hF8000000;
    push_instr(IR, 0, -1, 0);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    IR = 32'h18000000;
    push_instr(IR, 0, 3, 0);
    for (int c = 0; c < 5; c++) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL partial_seq cyc %0d: got %h, expected %h", c, ctl, exp_w);
      end
      if (c < 4) @(negedge Clock);
    end
    exp_q.delete(); mem_q.delete(); stop_q.delete();
    Clear = 1'b0; #1;
    n_compared++;
    if (ctl !== B_RUN) begin
      n_mismatched++;
      $display("[TB] FAIL clear_mid: got %h, expected %h", ctl, B_RUN);
    end
    @(negedge Clock);
    Clear = 1'b1;
    push_instr(IR, 0, -1, 0);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL after_clear_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    #1;
    n_compared++;
    if (ctl !== W_T0) begin
      n_mismatched++;
      $display("[TB] FAIL stop_flag_cleared: got %h, expected %h", ctl, W_T0);
    end
  endtask

  task automatic test_stop();
    int cyc = 0;
    IR = 32'h18000000;
    push_instr(IR, 0, 4, 3);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL stop_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
    #1;
    n_compared++;
    if (Run !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL halt_run: got %b, expected 0", Run);
    end
  endtask

  task automatic test_halt_opcode();
    int cyc = 0;
    Clear = 1'b0; #1;
    n_compared++;
    if (ctl !== B_RUN) begin
      n_mismatched++;
      $display("[TB] FAIL clear_from_halt: got %h, expected %h", ctl, B_RUN);
    end
    @(negedge Clock);
    Clear = 1'b1;
    IR = 32'hD8000000;
    push_instr(IR, 0, -1, 2);
    while (exp_q.size() != 0) begin
      MemReady = mem_q.pop_front(); Stop = stop_q.pop_front(); #1;
      exp_w = exp_q.pop_front();
      n_compared++;
      if (ctl !== exp_w) begin
        n_mismatched++;
        $display("[TB] FAIL halt_op_seq cyc %0d: got %h, expected %h", cyc, ctl, exp_w);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  initial begin
    $display("[TB] control_sequencer bench start");
    test_reset();
    test_and();
    test_mul();
    test_mem_stall();
    test_back_to_back();
    test_illegal_and_clear();
    test_stop();
    test_halt_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
